// File: rtl/control_unit_if.sv
// Datapath control bundle between the control unit (master) and the datapath (slave).
// Carries the run/ir/mem_rdy inputs and every strobe the control unit drives.
interface control_unit_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic [15:0] gpr_in;
    logic [15:0] gpr_out;
    logic        pc_out;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    logic        read;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        z_low_out;
    logic        z_high_out;
    logic        hi_in;
    logic        hi_out;
    logic        lo_in;
    logic        lo_out;
    logic [3:0]  alu_op;
    logic        halted;

    modport master (
        input  run, ir, mem_rdy,
        output gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
               read, ir_in, y_in, z_in, z_low_out, z_high_out,
               hi_in, hi_out, lo_in, lo_out, alu_op, halted
    );

    modport slave (
        output run, ir, mem_rdy,
        input  gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
               read, ir_in, y_in, z_in, z_low_out, z_high_out,
               hi_in, hi_out, lo_in, lo_out, alu_op, halted
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for three-register ALU ops (and, or, add, sub).
// Define CU_MEM_WAIT_EN to make T1 hold until mem_rdy; otherwise T1 is a single cycle.
module control_unit (
    input  logic           clk,
    input  logic           reset_n,
    control_unit_if.master cu
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        HALT = 3'd7
    } state_t;

    state_t     state_reg;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       op_ok;
    logic [3:0] op_alu;

    assign op = cu.ir[31:27];
    assign ra = cu.ir[26:23];
    assign rb = cu.ir[22:19];
    assign rc = cu.ir[18:15];

    always_comb begin
        op_ok  = 1'b1;
        op_alu = 4'b0000;
        case (op)
            5'b01001: op_alu = 4'b0000;
            5'b01010: op_alu = 4'b0001;
            5'b00011: op_alu = 4'b0010;
            5'b00100: op_alu = 4'b0011;
            default:  op_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: if (cu.run) state_reg <= T0;
                T0:   state_reg <= T1;
`ifdef CU_MEM_WAIT_EN
                T1:   if (cu.mem_rdy) state_reg <= T2;
`else
                T1:   state_reg <= T2;
`endif
                T2:   state_reg <= T3;
                T3:   state_reg <= op_ok ? T4 : HALT;
                T4:   state_reg <= T5;
                T5:   state_reg <= cu.run ? T0 : IDLE;
                HALT: state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CU_MEM_WAIT_EN
    logic unused_ok;
    assign unused_ok = 1'b1;
`else
    logic unused_ok;
    assign unused_ok = cu.mem_rdy;
`endif

    // Outputs follow state asynchronously, so an async reset clears them at once.
    always_comb begin
        cu.gpr_in    = 16'h0000;
        cu.gpr_out   = 16'h0000;
        cu.pc_out    = 1'b0;
        cu.inc_pc    = 1'b0;
        cu.mar_in    = 1'b0;
        cu.mdr_in    = 1'b0;
        cu.mdr_out   = 1'b0;
        cu.read      = 1'b0;
        cu.ir_in     = 1'b0;
        cu.y_in      = 1'b0;
        cu.z_in      = 1'b0;
        cu.z_low_out = 1'b0;
        cu.alu_op    = 4'b0000;
        cu.halted    = 1'b0;
        case (state_reg)
            T0: begin
                cu.pc_out = 1'b1;
                cu.mar_in = 1'b1;
                cu.inc_pc = 1'b1;
            end
            T1: begin
                cu.read   = 1'b1;
                cu.mdr_in = 1'b1;
            end
            T2: begin
                cu.mdr_out = 1'b1;
                cu.ir_in   = 1'b1;
            end
            T3: begin
                if (op_ok) begin
                    cu.gpr_out = 16'h0001 << rb;
                    cu.y_in    = 1'b1;
                end
            end
            T4: begin
                cu.gpr_out = 16'h0001 << rc;
                cu.z_in    = 1'b1;
                cu.alu_op  = op_alu;
            end
            T5: begin
                cu.gpr_in    = 16'h0001 << ra;
                cu.z_low_out = 1'b1;
            end
            HALT: cu.halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath strobes not used by the supported op set are tied low.
    assign cu.pc_in      = 1'b0;
    assign cu.z_high_out = 1'b0;
    assign cu.hi_in      = 1'b0;
    assign cu.hi_out     = 1'b0;
    assign cu.lo_in      = 1'b0;
    assign cu.lo_out     = 1'b0;
endmodule
